stopwatch_mmss: RTL and testbench
=================================

// Module: stopwatch_mmss
// PURPOSE
//  Downstream consumer of the periodic timer pulse: counts 1 s ticks into a BCD mm:ss stopwatch.
//  - Start/stop/clear control via single-cycle pulses (debounced upstream).
//  - Registered BCD digits feed the 7-segment display driver.
//  - Run/pause/idle FSM; configurable wrap vs. saturate at 59:59.
// PARAMETERS
//  WRAP         1  1: 59:59 -> 00:00 with o_Rollover pulse; 0: hold at 59:59, no pulse
//  MIN_TENS_MAX 5  max value of minutes-tens digit (5 => 59 min; legal range 1..9)
// PORTS
//  i_Clk         in   1  system clock, all logic on posedge
//  i_Rst         in   1  synchronous reset, active-high
//  i_Tick        in   1  1-cycle pulse per counted second (from timer)
//  i_Start_Stop  in   1  1-cycle pulse: start / pause / resume
//  i_Clear       in   1  1-cycle pulse: zero count, go IDLE
//  i_Lap         in   1  1-cycle pulse: lap freeze toggle (see CONFIGURATION)
//  o_Sec_Ones    out  4  BCD 0..9
//  o_Sec_Tens    out  4  BCD 0..5
//  o_Min_Ones    out  4  BCD 0..9
//  o_Min_Tens    out  4  BCD 0..MIN_TENS_MAX
//  o_Running     out  1  1 while FSM in RUN
//  o_Rollover    out  1  1-cycle pulse on wrap to 00:00 (WRAP=1 only)
//  o_Lap_Active  out  1  1 while display frozen
// BEHAVIOUR
//  - Reset (i_Rst=1, sync): FSM=IDLE, all digits 0, o_Running=0, o_Rollover=0, o_Lap_Active=0.
//  - FSM: IDLE --Start_Stop--> RUN; RUN --Start_Stop--> PAUSED; PAUSED --Start_Stop--> RUN;
//    any state --Clear--> IDLE (count zeroed).
//  - Priority per cycle: i_Rst > i_Clear > {i_Start_Stop, i_Tick}.
//  - Tick is counted iff the CURRENT state is RUN (pre-transition):
//    RUN + Start_Stop + Tick -> count increments AND state becomes PAUSED;
//    IDLE/PAUSED + Start_Stop + Tick -> state becomes RUN, tick NOT counted.
//  - Ticks in IDLE/PAUSED ignored. Clear + Tick same cycle -> 00:00, IDLE.
//  - Latency: digits update on the clock edge sampling i_Tick (visible next cycle).
//  - BCD carry chain: Sec_Ones 9->0 carries to Sec_Tens; Sec_Tens 5->0 carries to
//    Min_Ones; Min_Ones 9->0 carries to Min_Tens; Min_Tens at MIN_TENS_MAX with all
//    lower digits max = terminal value (e.g. 59:59).
//  - Terminal + counted tick: WRAP=1 -> 00:00, o_Rollover=1 for exactly that one cycle,
//    stays RUN; WRAP=0 -> digits hold, o_Rollover stays 0, stays RUN.
//  - o_Running is registered: equals (state==RUN) one cycle after transition edge.
//  - Digits never take non-BCD or out-of-range values.
//  - Reset/Clear mid-count: immediate zero next cycle, no rollover pulse.
// CONFIGURATION
//  STOPWATCH_LAP_EN defined:
//   - i_Lap in RUN or PAUSED: if not frozen, capture live digits into lap register,
//     outputs show lap value, o_Lap_Active=1; if frozen, release to live digits.
//   - Internal count continues while frozen; i_Lap ignored in IDLE.
//   - i_Clear / i_Rst release freeze (o_Lap_Active=0); rollover still pulses while frozen.
//  STOPWATCH_LAP_EN undefined:
//   - i_Lap ignored, outputs always live, o_Lap_Active tied 0; no lap register.
//  Port list identical in both builds.
// TESTING
//  1. Rst, Start_Stop, 75 ticks -> digits 01:15, o_Running=1.
//  2. RUN at 00:09, Start_Stop+Tick same cycle -> 00:10, state PAUSED; 5 more ticks -> 00:10.
//  3. WRAP=1, preload to 59:59 via ticks, one tick -> 00:00, o_Rollover high exactly 1 cycle.
//  4. WRAP=0 at 59:59, 3 ticks -> stays 59:59, o_Rollover never 1, o_Running=1.
//  5. RUN at 00:30, Clear+Tick same cycle -> 00:00, o_Running=0; Start_Stop+Tick from IDLE -> 00:00, RUN.
//  6. LAP_EN: at 00:20 i_Lap, 10 ticks -> outputs 00:20, o_Lap_Active=1; i_Lap -> 00:30, o_Lap_Active=0.

Source files
------------

// File: rtl/stopwatch_mmss_if.sv
// Control pulses and display outputs of the mm:ss stopwatch, bundled as one port.
// Latency: none (wiring only).
// Backpressure: none; every input is a single-cycle pulse, outputs are levels or pulses.
interface stopwatch_mmss_if;
    // Control pulses toward the stopwatch
    logic       i_Tick;
    logic       i_Start_Stop;
    logic       i_Clear;
    logic       i_Lap;

    // Display digits and status from the stopwatch
    logic [3:0] o_Sec_Ones;
    logic [3:0] o_Sec_Tens;
    logic [3:0] o_Min_Ones;
    logic [3:0] o_Min_Tens;
    logic       o_Running;
    logic       o_Rollover;
    logic       o_Lap_Active;

    // Controller side: drives the pulses, observes the display
    modport master (
        output i_Tick, i_Start_Stop, i_Clear, i_Lap,
        input  o_Sec_Ones, o_Sec_Tens, o_Min_Ones, o_Min_Tens,
        input  o_Running, o_Rollover, o_Lap_Active
    );

    // Stopwatch side: consumes the pulses, drives the display
    modport slave (
        input  i_Tick, i_Start_Stop, i_Clear, i_Lap,
        output o_Sec_Ones, o_Sec_Tens, o_Min_Ones, o_Min_Tens,
        output o_Running, o_Rollover, o_Lap_Active
    );
endinterface

// File: rtl/stopwatch_mmss.sv
// BCD mm:ss stopwatch counting 1 s tick pulses, with idle/run/paused control.
// Latency: digits, o_Running and o_Rollover update on the edge that samples the input pulse.
// Backpressure: none; pulses are consumed every cycle. Lap freeze built only with STOPWATCH_LAP_EN.
module stopwatch_mmss #(
    parameter int WRAP         = 1,   // 1: 59:59 wraps to 00:00 with a rollover pulse; 0: saturate
    parameter int MIN_TENS_MAX = 5    // top value of the minutes-tens digit, 1..9
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    stopwatch_mmss_if.slave sw
);

    localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    // Live count, always counting regardless of any lap freeze
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;

    logic [3:0] sec_ones_nxt;
    logic [3:0] sec_tens_nxt;
    logic [3:0] min_ones_nxt;
    logic [3:0] min_tens_nxt;

    logic       count_en;
    logic       at_terminal;
    logic       wrap_now;
    logic       running_q;
    logic       rollover_q;

    // A tick only counts when the state before this edge is RUN; Clear wins over it
    assign count_en    = (state == ST_RUN) && sw.i_Tick && !sw.i_Clear;

    assign at_terminal = (sec_ones == 4'd9) && (sec_tens == 4'd5) &&
                         (min_ones == 4'd9) && (min_tens == MT_MAX);

    assign wrap_now    = count_en && at_terminal && (WRAP != 0);

    // Next-state logic: Clear forces IDLE, Start_Stop toggles between run and pause
    always_comb begin
        state_nxt = state;
        if (sw.i_Clear) begin
            state_nxt = ST_IDLE;
        end else if (sw.i_Start_Stop) begin
            case (state)
                ST_IDLE:   state_nxt = ST_RUN;
                ST_RUN:    state_nxt = ST_PAUSED;
                ST_PAUSED: state_nxt = ST_RUN;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // BCD carry chain; at the terminal value either wrap to zero or hold
    always_comb begin
        sec_ones_nxt = sec_ones;
        sec_tens_nxt = sec_tens;
        min_ones_nxt = min_ones;
        min_tens_nxt = min_tens;
        if (count_en) begin
            if (at_terminal) begin
                if (WRAP != 0) begin
                    sec_ones_nxt = 4'd0;
                    sec_tens_nxt = 4'd0;
                    min_ones_nxt = 4'd0;
                    min_tens_nxt = 4'd0;
                end
            end else if (sec_ones != 4'd9) begin
                sec_ones_nxt = sec_ones + 4'd1;
            end else begin
                sec_ones_nxt = 4'd0;
                if (sec_tens != 4'd5) begin
                    sec_tens_nxt = sec_tens + 4'd1;
                end else begin
                    sec_tens_nxt = 4'd0;
                    if (min_ones != 4'd9) begin
                        min_ones_nxt = min_ones + 4'd1;
                    end else begin
                        // Not terminal here, so min_tens is below MT_MAX
                        min_ones_nxt = 4'd0;
                        min_tens_nxt = min_tens + 4'd1;
                    end
                end
            end
        end
    end

    // Digit registers; Reset and Clear zero the count immediately
    always_ff @(posedge i_Clk) begin
        if (i_Rst || sw.i_Clear) begin
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
        end else begin
            sec_ones <= sec_ones_nxt;
            sec_tens <= sec_tens_nxt;
            min_ones <= min_ones_nxt;
            min_tens <= min_tens_nxt;
        end
    end

    // Registered status: running tracks the new state, rollover pulses on the wrapping tick
    always_ff @(posedge i_Clk) begin
        if (i_Rst || sw.i_Clear) begin
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            running_q  <= (state_nxt == ST_RUN);
            rollover_q <= wrap_now;
        end
    end

    assign sw.o_Running  = running_q;
    assign sw.o_Rollover = rollover_q;

`ifdef STOPWATCH_LAP_EN
    logic [3:0] lap_sec_ones;
    logic [3:0] lap_sec_tens;
    logic [3:0] lap_min_ones;
    logic [3:0] lap_min_tens;
    logic       lap_active;

    // Lap toggle outside IDLE: first press snapshots the pre-tick count, second press releases
    always_ff @(posedge i_Clk) begin
        if (i_Rst || sw.i_Clear) begin
            lap_active   <= 1'b0;
            lap_sec_ones <= 4'd0;
            lap_sec_tens <= 4'd0;
            lap_min_ones <= 4'd0;
            lap_min_tens <= 4'd0;
        end else if (sw.i_Lap && (state != ST_IDLE)) begin
            if (!lap_active) begin
                lap_active   <= 1'b1;
                lap_sec_ones <= sec_ones;
                lap_sec_tens <= sec_tens;
                lap_min_ones <= min_ones;
                lap_min_tens <= min_tens;
            end else begin
                lap_active   <= 1'b0;
            end
        end
    end

    assign sw.o_Sec_Ones   = lap_active ? lap_sec_ones : sec_ones;
    assign sw.o_Sec_Tens   = lap_active ? lap_sec_tens : sec_tens;
    assign sw.o_Min_Ones   = lap_active ? lap_min_ones : min_ones;
    assign sw.o_Min_Tens   = lap_active ? lap_min_tens : min_tens;
    assign sw.o_Lap_Active = lap_active;
`else
    assign sw.o_Sec_Ones   = sec_ones;
    assign sw.o_Sec_Tens   = sec_tens;
    assign sw.o_Min_Ones   = min_ones;
    assign sw.o_Min_Tens   = min_tens;
    // No lap feature: output held low; the input is only sampled so the port stays connected
    assign sw.o_Lap_Active = 1'b0 & sw.i_Lap;
`endif

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Bench for stopwatch_mmss: a wrapping 59:59 unit and a saturating 19:59 unit share stimulus.
// Latency: expectations are queued when a cycle is driven and popped after its clock edge.
// Backpressure: none; the lap-freeze expectations follow whether STOPWATCH_LAP_EN is defined.
module tb_stopwatch_mmss;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    localparam int TERM_W = 3599;   // 59:59
    localparam int TERM_S = 1199;   // 19:59

    logic i_Clk = 1'b0;
    logic i_Rst = 1'b0;

    always #5 i_Clk = ~i_Clk;

    stopwatch_mmss_if if_w();
    stopwatch_mmss_if if_s();

    stopwatch_mmss #(.WRAP(1), .MIN_TENS_MAX(5)) u_dut_w (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .sw    (if_w)
    );

    stopwatch_mmss #(.WRAP(0), .MIN_TENS_MAX(1)) u_dut_s (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .sw    (if_s)
    );

    typedef struct {
        int state;      // 0 idle, 1 run, 2 paused
        int cnt;        // live seconds
        int lap_cnt;
        bit lap_act;
        bit run;
        bit roll;
    } mdl_t;

    typedef struct {
        logic [15:0] dig;
        bit          run;
        bit          roll;
        bit          lap;
    } obs_t;

    mdl_t mw;
    mdl_t ms;
    obs_t q_w[$];
    obs_t q_s[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int c);
        int m;
        int s;
        m = c / 60;
        s = c % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // Behavioural model on a plain seconds count
    function automatic mdl_t mdl_step(input mdl_t m, input bit wrap, input int term,
                                      input bit rst, input bit tick, input bit ss,
                                      input bit clr, input bit lap);
        mdl_t n;
        n = m;
        if (rst || clr) begin
            n.state = 0; n.cnt = 0; n.lap_cnt = 0;
            n.lap_act = 1'b0; n.run = 1'b0; n.roll = 1'b0;
            return n;
        end
        n.roll = 1'b0;
        if (LAP_EN && lap && m.state != 0) begin
            if (!m.lap_act) begin
                n.lap_cnt = m.cnt;
                n.lap_act = 1'b1;
            end else begin
                n.lap_act = 1'b0;
            end
        end
        if (m.state == 1 && tick) begin
            if (m.cnt == term) begin
                if (wrap) begin
                    n.cnt  = 0;
                    n.roll = 1'b1;
                end
            end else begin
                n.cnt = m.cnt + 1;
            end
        end
        if (ss) n.state = (m.state == 1) ? 2 : 1;
        n.run = (n.state == 1);
        return n;
    endfunction

    function automatic obs_t expect_of(input mdl_t m);
        obs_t o;
        o.dig  = to_bcd(m.lap_act ? m.lap_cnt : m.cnt);
        o.run  = m.run;
        o.roll = m.roll;
        o.lap  = m.lap_act;
        return o;
    endfunction

    // Drive one cycle on both units, queue the expectation, compare after the edge
    task automatic cyc(input bit rst, input bit tick, input bit ss, input bit clr, input bit lap);
        obs_t e;
        i_Rst = rst;
        if_w.i_Tick = tick; if_w.i_Start_Stop = ss; if_w.i_Clear = clr; if_w.i_Lap = lap;
        if_s.i_Tick = tick; if_s.i_Start_Stop = ss; if_s.i_Clear = clr; if_s.i_Lap = lap;
        mw = mdl_step(mw, 1'b1, TERM_W, rst, tick, ss, clr, lap);
        ms = mdl_step(ms, 1'b0, TERM_S, rst, tick, ss, clr, lap);
        q_w.push_back(expect_of(mw));
        q_s.push_back(expect_of(ms));
        @(posedge i_Clk);
        #1;
        i_Rst = 1'b0;
        if_w.i_Tick = 1'b0; if_w.i_Start_Stop = 1'b0; if_w.i_Clear = 1'b0; if_w.i_Lap = 1'b0;
        if_s.i_Tick = 1'b0; if_s.i_Start_Stop = 1'b0; if_s.i_Clear = 1'b0; if_s.i_Lap = 1'b0;
        if (q_w.size() == 0 || q_s.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            e = q_w.pop_front();
            check("w_digits",  {if_w.o_Min_Tens, if_w.o_Min_Ones, if_w.o_Sec_Tens, if_w.o_Sec_Ones}, e.dig);
            check("w_running", if_w.o_Running,    e.run);
            check("w_rollover", if_w.o_Rollover,  e.roll);
            check("w_lap",     if_w.o_Lap_Active, e.lap);
            e = q_s.pop_front();
            check("s_digits",  {if_s.o_Min_Tens, if_s.o_Min_Ones, if_s.o_Sec_Tens, if_s.o_Sec_Ones}, e.dig);
            check("s_running", if_s.o_Running,    e.run);
            check("s_rollover", if_s.o_Rollover,  e.roll);
            check("s_lap",     if_s.o_Lap_Active, e.lap);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [15:0] w_digits();
        return {if_w.o_Min_Tens, if_w.o_Min_Ones, if_w.o_Sec_Tens, if_w.o_Sec_Ones};
    endfunction

    function automatic logic [15:0] s_digits();
        return {if_s.o_Min_Tens, if_s.o_Min_Ones, if_s.o_Sec_Tens, if_s.o_Sec_Ones};
    endfunction

    initial begin
        mw = '{default: 0};
        ms = '{default: 0};
        if_w.i_Tick = 1'b0; if_w.i_Start_Stop = 1'b0; if_w.i_Clear = 1'b0; if_w.i_Lap = 1'b0;
        if_s.i_Tick = 1'b0; if_s.i_Start_Stop = 1'b0; if_s.i_Clear = 1'b0; if_s.i_Lap = 1'b0;
        #2;

        // Reset state, then ticks and lap pulses in IDLE are ignored
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("reset_digits", w_digits(), 16'h0000);
        check("reset_running", if_w.o_Running, 1'b0);
        ticks(3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("idle_ignore", w_digits(), 16'h0000);
        check("idle_lap", if_w.o_Lap_Active, 1'b0);

        // Start and count 75 seconds
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(75);
        check("t1_digits", w_digits(), 16'h0115);
        check("t1_running", if_w.o_Running, 1'b1);

        // Pause on the same cycle as a tick: the tick still counts
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(9);
        check("t2_pre", w_digits(), 16'h0009);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        ticks(5);
        check("t2_paused", w_digits(), 16'h0010);
        check("t2_running", if_w.o_Running, 1'b0);
        // Resume with a tick: not counted
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t2_resume", w_digits(), 16'h0010);
        check("t2_resume_run", if_w.o_Running, 1'b1);

        // Lap freeze and release
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(20);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(10);
        check("t6_frozen", w_digits(), LAP_EN ? 16'h0020 : 16'h0030);
        check("t6_active", if_w.o_Lap_Active, LAP_EN);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t6_release", w_digits(), 16'h0030);
        check("t6_inactive", if_w.o_Lap_Active, 1'b0);

        // Clear + Tick in RUN, then Start + Tick from IDLE
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(30);
        check("t5_pre", w_digits(), 16'h0030);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t5_clear", w_digits(), 16'h0000);
        check("t5_clear_run", if_w.o_Running, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t5_start", w_digits(), 16'h0000);
        check("t5_start_run", if_w.o_Running, 1'b1);

        // Full range: wrap on one unit, saturate on the other (freeze during wrap if built)
        ticks(TERM_W - 5);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(5);
        check("t3_term_live", u_dut_w.sec_ones, 4'd9);
        check("t4_sat", s_digits(), 16'h1959);
        ticks(1);
        check("t3_roll", if_w.o_Rollover, 1'b1);
        check("t4_no_roll", if_s.o_Rollover, 1'b0);
        check("t4_running", if_s.o_Running, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_roll_once", if_w.o_Rollover, 1'b0);
        check("t3_wrapped", w_digits(), 16'h0000);
        ticks(3);
        check("t4_hold", s_digits(), 16'h1959);

        // Reset mid-count
        ticks(7);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_mid", w_digits(), 16'h0000);

        // Random mix of all controls
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 200) == 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 60) == 0),
                ($urandom_range(0, 12) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
